// File: rtl/interrup_sched.sv
// Interrupt scheduler: latches rising-edge requests on four I/O ports, masks them,
// and hands the CPU one fixed-priority subroutine vector at a time, with the return PC saved.
module interrup_sched #(
  parameter int unsigned       ADDR_W = 10,
  parameter logic [ADDR_W-1:0] SUB1   = ADDR_W'(824),
  parameter logic [ADDR_W-1:0] SUB2   = ADDR_W'(874),
  parameter logic [ADDR_W-1:0] SUB3   = ADDR_W'(924),
  parameter logic [ADDR_W-1:0] SUB4   = ADDR_W'(974)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iport1,
  input  logic              iport2,
  input  logic              iport3,
  input  logic              iport4,
  input  logic              fin,
  input  logic [ADDR_W-1:0] pc_actual,
  input  logic              we_mask,
  input  logic [3:0]        mask_in,
  output logic [ADDR_W-1:0] dir,
  output logic              s_interrup,
  output logic [ADDR_W-1:0] dir_ret,
  output logic              s_retorno,
  output logic              active,
  output logic [3:0]        pending
);

  localparam int unsigned N_PORTS = 4;

  typedef enum logic [1:0] {
    IDLE,
    TAKE,
    SERVICE,
    RETURN
  } state_t;

  state_t              state;
  logic [N_PORTS-1:0]  iport_vec;
  logic [N_PORTS-1:0]  prev;
  logic [N_PORTS-1:0]  mask;
  logic [N_PORTS-1:0]  req_edge;
  logic [N_PORTS-1:0]  eligible;
  logic [N_PORTS-1:0]  grant;
  logic [N_PORTS-1:0]  clr;
  logic [ADDR_W-1:0]   grant_vec;
  logic                take_now;

  // Edge detect, eligibility and fixed-priority grant (port 1 wins)
  always_comb begin
    iport_vec = {iport4, iport3, iport2, iport1};
    req_edge  = iport_vec & ~prev;
    eligible  = pending & ~mask;
    grant     = '0;
    grant_vec = SUB1;
    if (eligible[0]) begin
      grant     = 4'b0001;
      grant_vec = SUB1;
    end else if (eligible[1]) begin
      grant     = 4'b0010;
      grant_vec = SUB2;
    end else if (eligible[2]) begin
      grant     = 4'b0100;
      grant_vec = SUB3;
    end else if (eligible[3]) begin
      grant     = 4'b1000;
      grant_vec = SUB4;
    end
    take_now = (state == IDLE) && (|eligible);
    clr      = take_now ? grant : '0;
  end

  // State, request latching and registered handshake outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      prev       <= '0;
      mask       <= '0;
      pending    <= '0;
      dir        <= '0;
      dir_ret    <= '0;
      s_interrup <= 1'b0;
      s_retorno  <= 1'b0;
      active     <= 1'b0;
    end else begin
      prev       <= iport_vec;
      s_interrup <= 1'b0;
      s_retorno  <= 1'b0;
      if (we_mask) begin
        mask <= mask_in;
      end
      // A fresh edge on the port being serviced keeps its bit set
      pending <= (pending & ~clr) | req_edge;

      case (state)
        IDLE: begin
          if (take_now) begin
            state      <= TAKE;
            dir        <= grant_vec;
            dir_ret    <= pc_actual;
            s_interrup <= 1'b1;
            active     <= 1'b1;
          end
        end
        TAKE: begin
          state <= SERVICE;
        end
        SERVICE: begin
          if (fin) begin
            state     <= RETURN;
            s_retorno <= 1'b1;
          end
        end
        RETURN: begin
          state  <= IDLE;
          active <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          active <= 1'b0;
        end
      endcase
    end
  end

endmodule
